// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle fetch/decode sequencer upstream of the program counter.
// Loads the start vector, fetches from a registered imem, decodes and drives PC strobes.
module fetch_ctrl #(
    parameter logic [7:0]  RESET_VECTOR = 8'h00,
    parameter int unsigned EXEC_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  pc_addr,
    output logic        imem_en,
    output logic [3:0]  imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        zero_flag,
    input  logic        exec_done,
    output logic        incPC,
    output logic        loadPC,
    output logic [7:0]  selPC,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        halted,
    output logic        err,
    output logic [7:0]  instr_count
);
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [7:0] TMO_LIM = 8'(EXEC_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FETCH, S_WAIT, S_DECODE, S_EXEC, S_UPDATE, S_HALTED
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  tgt_q, tgt_d;
    logic        ld_q, ld_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_inc;
    logic [7:0]  tmo_inc;
    logic [3:0]  opcode;

    assign opcode  = ir_q[15:12];
    assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    assign tmo_inc = tmo_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            tgt_q   <= '0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            tgt_q   <= tgt_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
        end
    end

    // Strobes are decoded from the state register only, so an async reset
    // removes them in the same instant it returns the FSM to IDLE.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        tgt_d     = tgt_q;
        ld_d      = ld_q;
        err_d     = err_q;
        imem_en   = 1'b0;
        imem_addr = 4'h0;
        incPC     = 1'b0;
        loadPC    = 1'b0;
        selPC     = 8'h00;
        ir_valid  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_INIT;
            end
            S_INIT: begin
                loadPC  = 1'b1;
                selPC   = RESET_VECTOR;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_en   = 1'b1;
                imem_addr = pc_addr;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                ir_d    = imem_rdata;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_valid = 1'b1;
                tgt_d    = ir_q[7:0];
                case (opcode)
                    OP_HALT: begin
                        cnt_d   = cnt_inc;
                        state_d = S_HALTED;
                    end
                    OP_JMP: begin
                        ld_d    = 1'b1;
                        state_d = S_UPDATE;
                    end
                    OP_BZ: begin
                        ld_d    = zero_flag;
                        state_d = S_UPDATE;
                    end
                    OP_NOP: begin
                        ld_d    = 1'b0;
                        state_d = S_UPDATE;
                    end
                    default: begin
                        tmo_d   = 8'h00;
                        state_d = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                ir_valid = 1'b1;
                tmo_d    = tmo_inc;
                // done on the expiry cycle still retires normally
                if (exec_done) begin
                    ld_d    = 1'b0;
                    state_d = S_UPDATE;
                end else if (tmo_inc == TMO_LIM) begin
                    err_d   = 1'b1;
                    state_d = S_HALTED;
                end
            end
            S_UPDATE: begin
                if (ld_q) begin
                    loadPC = 1'b1;
                    selPC  = tgt_q;
                end else begin
                    incPC  = 1'b1;
                end
                cnt_d   = cnt_inc;
                state_d = S_FETCH;
            end
            S_HALTED: begin
                halted = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ir          = ir_q;
    assign err         = err_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a procedural instruction-level model predicts every output
// each cycle; an external PC and registered imem close the loop around the DUT.
module tb_fetch_ctrl;
    localparam logic [7:0] RV  = 8'h00;
    localparam int         TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n, run, zero_flag, exec_done;
    logic [3:0]  pc, imem_addr;
    logic        imem_en, incPC, loadPC, ir_valid, halted, err;
    logic [15:0] imem_rdata, ir;
    logic [7:0]  selPC, instr_count;
    logic [15:0] mem [16];

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_VECTOR(RV), .EXEC_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .pc_addr(pc),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .zero_flag(zero_flag), .exec_done(exec_done),
        .incPC(incPC), .loadPC(loadPC), .selPC(selPC),
        .ir(ir), .ir_valid(ir_valid), .halted(halted), .err(err),
        .instr_count(instr_count)
    );

    // Environment: un-reset PC and registered instruction memory
    always @(posedge clk) begin
        if (loadPC)      pc <= selPC[3:0];
        else if (incPC)  pc <= pc + 4'd1;
        if (imem_en) imem_rdata <= mem[imem_addr];
    end

    int n_chk = 0, n_err = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Model state and expected outputs
    logic [3:0]  m_pc;
    logic [15:0] m_ir;
    logic [7:0]  m_cnt;
    logic        m_err;
    logic        e_en, e_inc, e_load, e_irv, e_halted, e_err;
    logic [3:0]  e_addr;
    logic [7:0]  e_sel, e_cnt;
    logic [15:0] e_ir;
    bit          chk_en = 0;

    // Per-episode observation logs for hand-computed expectations
    logic [3:0] fetch_log[$];
    int         fetch_cyc[$];
    int         inc_cyc[$];
    int         n_load, n_irv, run_cyc, halt_cnt, last_cnt;
    bit         saw_err;

    always @(negedge clk) if (chk_en) begin
        chk("imem_en",     32'(imem_en),     32'(e_en));
        chk("imem_addr",   32'(imem_addr),   32'(e_addr));
        chk("incPC",       32'(incPC),       32'(e_inc));
        chk("loadPC",      32'(loadPC),      32'(e_load));
        chk("selPC",       32'(selPC),       32'(e_sel));
        chk("ir",          32'(ir),          32'(e_ir));
        chk("ir_valid",    32'(ir_valid),    32'(e_irv));
        chk("halted",      32'(halted),      32'(e_halted));
        chk("err",         32'(err),         32'(e_err));
        chk("instr_count", 32'(instr_count), 32'(e_cnt));
        if (imem_en) begin fetch_log.push_back(imem_addr); fetch_cyc.push_back(cyc); end
        if (incPC) inc_cyc.push_back(cyc);
        if (loadPC) n_load++;
        if (ir_valid) n_irv++;
        if (halted) begin halt_cnt = instr_count; saw_err = err; end
        if (rst_n) last_cnt = instr_count;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] sat(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    // Quiet outputs for the cycle, random don't-care inputs
    task automatic base();
        e_en = 0; e_addr = 0; e_inc = 0; e_load = 0; e_sel = 0; e_irv = 0; e_halted = 0;
        e_ir = m_ir; e_err = m_err; e_cnt = m_cnt;
        run = 1'($urandom); zero_flag = 1'($urandom); exec_done = 1'($urandom);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_ir = 0; m_cnt = 0; m_err = 0;
        base();
        run = 0;
        #1;
        chk("rst_now_incPC", 32'(incPC), 0);
        chk("rst_now_loadPC", 32'(loadPC), 0);
        chk("rst_now_halted", 32'(halted), 0);
        chk("rst_now_count", 32'(instr_count), 0);
        step();
        rst_n = 1'b1;
    endtask

    task automatic halt_tail();
        repeat (3) begin base(); e_halted = 1; step(); end
        do_reset();
    endtask

    function automatic int pick_n();
        int r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(1, 5);
        if (r < 8) return TMO;
        return 99;
    endfunction

    task automatic episode(input int max_instr, input int rst_exec_at, input bit rand_zf,
                           input logic [31:0] zf_pat, input int exec_n);
        logic [3:0] op;
        logic [7:0] tgt;
        bit         ld;
        int         nexec;
        fetch_log.delete(); fetch_cyc.delete(); inc_cyc.delete();
        n_load = 0; n_irv = 0; halt_cnt = -1; saw_err = 0; last_cnt = 0;
        repeat ($urandom_range(0, 2)) begin base(); run = 0; step(); end
        base(); run = 1; run_cyc = cyc; step();
        base(); e_load = 1; e_sel = RV; step();
        m_pc = RV[3:0];
        for (int i = 0; i < max_instr; i++) begin
            base(); e_en = 1; e_addr = m_pc; step();
            base(); step();
            m_ir = mem[m_pc];
            op  = m_ir[15:12];
            tgt = m_ir[7:0];
            base(); e_irv = 1;
            if (!rand_zf) zero_flag = zf_pat[i % 32];
            ld = (op == 4'hC) || (op == 4'hD && zero_flag);
            step();
            if (op == 4'hF) begin m_cnt = sat(m_cnt); halt_tail(); return; end
            if (!(op inside {4'h0, 4'hC, 4'hD})) begin
                nexec = (exec_n != 0) ? exec_n : pick_n();
                if (i == rst_exec_at) nexec = 6;
                for (int k = 1; k <= 200; k++) begin
                    base(); e_irv = 1; exec_done = (k == nexec);
                    if (i == rst_exec_at && k == 2) begin do_reset(); return; end
                    step();
                    if (k == nexec) break;
                    if (k == TMO) begin m_err = 1; halt_tail(); return; end
                end
            end
            base();
            if (i == max_instr - 1) begin do_reset(); return; end
            if (ld) begin e_load = 1; e_sel = tgt; end else e_inc = 1;
            step();
            m_cnt = sat(m_cnt);
            m_pc  = ld ? tgt[3:0] : m_pc + 4'd1;
        end
        do_reset();
    endtask

    task automatic chk_fetch(input string nm, input int n, input logic [63:0] seq);
        chk({nm, "_nfetch"}, fetch_log.size(), n);
        if (fetch_log.size() == n)
            for (int j = 0; j < n; j++) chk({nm, "_addr"}, 32'(fetch_log[j]), 32'(seq[4*j +: 4]));
    endtask

    task automatic clr_mem();
        for (int a = 0; a < 16; a++) mem[a] = 16'h0000;
    endtask

    function automatic logic [15:0] rand_instr();
        int r = $urandom_range(0, 15);
        logic [7:0] imm = 8'($urandom);
        if (r < 5)  return 16'h0000;
        if (r < 7)  return {4'hC, 4'h0, imm};
        if (r < 9)  return {4'hD, 4'h0, imm};
        if (r < 14) return {4'($urandom_range(1, 11)), 4'h0, imm};
        if (r < 15) return {4'hE, 4'h0, imm};
        return 16'hF000;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; run = 0; zero_flag = 0; exec_done = 0; pc = 4'hA; imem_rdata = 0;
        m_pc = 0; m_ir = 0; m_cnt = 0; m_err = 0;
        clr_mem();
        base(); run = 0;
        chk_en = 1;
        #2;
        chk("reset_ir", 32'(ir), 0);
        chk("reset_count", 32'(instr_count), 0);
        chk("reset_imem_en", 32'(imem_en), 0);
        step(); step();
        rst_n = 1;

        // NOP, NOP, HALT at 2
        clr_mem(); mem[2] = 16'hF000;
        episode(100, -1, 1, 0, 0);
        chk_fetch("nop", 3, 64'h210);
        chk("nop_first_fetch_lat", fetch_cyc.size() > 0 ? fetch_cyc[0] - run_cyc : -1, 2);
        chk("nop_inc_n", inc_cyc.size(), 2);
        if (inc_cyc.size() == 2) chk("nop_inc_spacing", inc_cyc[1] - inc_cyc[0], 4);
        chk("halt_count", halt_cnt, 3);

        // JMP 0x05
        clr_mem(); mem[0] = 16'hC005; mem[5] = 16'hF000;
        episode(100, -1, 1, 0, 0);
        chk_fetch("jmp", 2, 64'h50);
        chk("jmp_loads", n_load, 2);

        // BZ not taken then taken
        clr_mem(); mem[0] = 16'hD009; mem[1] = 16'hD009; mem[9] = 16'hF000;
        episode(100, -1, 0, 32'b10, 0);
        chk_fetch("bz", 3, 64'h910);
        chk("bz_incs", inc_cyc.size(), 1);

        // Datapath op finishing on its 3rd EXEC cycle
        clr_mem(); mem[0] = 16'h3000; mem[1] = 16'hF000;
        episode(100, -1, 1, 0, 3);
        chk("dp_irv_cycles", n_irv, 5);
        chk("dp_incs", inc_cyc.size(), 1);
        if (fetch_cyc.size() == 2) chk("dp_instr_len", fetch_cyc[1] - fetch_cyc[0], 7);
        else chk("dp_nfetch", fetch_cyc.size(), 2);

        // Exec timeout
        clr_mem(); mem[0] = 16'h3000;
        episode(100, -1, 1, 0, 99);
        chk("tmo_err", 32'(saw_err), 1);
        chk("tmo_incs", inc_cyc.size(), 0);
        chk("tmo_loads", n_load, 1);

        // Wide BZ target truncated to F, then wrap to 0
        clr_mem(); mem[0] = 16'hD0FF; mem[1] = 16'hF000;
        episode(100, -1, 0, 32'b001, 0);
        chk_fetch("wrap", 4, 64'h10F0);
        chk("wrap_no_err", 32'(saw_err), 0);
        chk("wrap_count", halt_cnt, 4);

        // Reset mid-EXEC, mid-UPDATE, then restart
        clr_mem(); mem[1] = 16'h3000;
        episode(100, 1, 1, 0, 0);
        clr_mem();
        episode(3, -1, 1, 0, 0);
        chk("upd_rst_count", last_cnt, 2);
        mem[2] = 16'hF000;
        episode(100, -1, 1, 0, 0);
        chk("restart_count", halt_cnt, 3);

        // Saturating retire counter
        clr_mem();
        episode(260, -1, 1, 0, 0);
        chk("sat_count", last_cnt, 255);

        // Randomized programs
        for (int e = 0; e < 14; e++) begin
            for (int a = 0; a < 16; a++) mem[a] = rand_instr();
            episode(25, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 20) : -1, 1, 0, 0);
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Multi-cycle fetch/decode sequencer sitting directly upstream of the program counter.
- Takes the PC's 4-bit instruction-memory address, issues reads to a registered instruction memory, and latches the returned word into an instruction register.
- Decodes the opcode, hands datapath operations to the execute stage over a done handshake, and drives incPC/loadPC/selPC back into the PC.
- The PC has no reset, so this block also loads the PC with a start vector before the first fetch.

Parameters:
RESET_VECTOR, 8'h00, PC value loaded on start; PC uses bits [3:0].
EXEC_TIMEOUT, 16, maximum EXEC cycles to wait for exec_done before error halt (legal range 1..255).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
run  input  1  start request, sampled only in IDLE
pc_addr  input  4  current PC value (ins_mem from the PC)
imem_en  output  1  instruction-memory read enable
imem_addr  output  4  instruction-memory read address
imem_rdata  input  16  read data, valid the cycle after imem_en
zero_flag  input  1  ALU zero flag, sampled in DECODE
exec_done  input  1  execute stage finished the current op
incPC  output  1  PC increment strobe
loadPC  output  1  PC load strobe
selPC  output  8  PC load value
ir  output  16  instruction register
ir_valid  output  1  ir holds a decoded instruction (DECODE/EXEC)
halted  output  1  sequencer stopped
err  output  1  exec timeout occurred
instr_count  output  8  retired instructions, saturating

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including ir, instr_count and the timeout counter.
  - Reset may assert in any state and takes effect immediately; no strobe may be emitted after it asserts.
- Instruction format:
  - [15:12] opcode; [11:8] rd (unused here); [7:0] imm.
  - Opcodes: 0x0 NOP, 0xC JMP, 0xD BZ, 0xF HALT; all others are datapath ops.
- States: IDLE, INIT, FETCH, WAIT, DECODE, EXEC, UPDATE, HALTED.
- IDLE: outputs idle. run=1 -> INIT.
- INIT (1 cycle): loadPC=1, selPC=RESET_VECTOR -> FETCH.
- FETCH (1 cycle): imem_en=1, imem_addr=pc_addr -> WAIT.
- WAIT (1 cycle): at exit edge, ir<=imem_rdata -> DECODE.
- DECODE (1 cycle): ir_valid=1.
  - HALT: instr_count++ -> HALTED.
  - JMP: -> UPDATE with load pending, target=imm.
  - BZ: zero_flag=1 -> load pending, target=imm; else inc pending. -> UPDATE.
  - NOP: inc pending -> UPDATE.
  - Datapath op: clear timeout counter -> EXEC.
- EXEC: ir_valid=1; counter increments each cycle.
  - exec_done=1 -> UPDATE, inc pending.
  - Else counter reaching EXEC_TIMEOUT -> err=1 -> HALTED.
  - exec_done on the expiry cycle: done wins.
- UPDATE (1 cycle):
  - Exactly one of incPC/loadPC=1; selPC=target when loading, else 0.
  - instr_count++ (saturates at 8'hFF).
  - -> FETCH.
  - The PC updates on this edge, so the next FETCH presents the new address.
- HALTED: halted=1, err held. Stays until rst_n; run is ignored.
- Strobe rules:
  - incPC and loadPC are never both 1.
  - Each is high for only one cycle per instruction.
  - Both are 0 outside INIT/UPDATE.
- Address wrap: PC 4'hF + inc wraps to 4'h0. This is legal and must not be flagged.
- Load width: selPC[7:4] is driven as given (imm); the PC truncates it.
- run after start: changes on run after leaving IDLE have no effect.
- Latency:
  - First fetch is 2 cycles after run is sampled.
  - NOP/JMP/BZ: 4 cycles each.
  - Datapath op: 4 + N cycles, where N = EXEC cycles including the done cycle.

Test Plan:
- Reset then run=1, RESET_VECTOR=0 -> loadPC=1/selPC=0 on the INIT cycle; imem_en=1 with imem_addr=0 on the next cycle.
- Memory holds NOP at addresses 0..2 -> incPC pulses at 4-cycle spacing, imem_addr sequence 0,1,2, instr_count=3.
- JMP 0x05 at addr 0 -> loadPC=1, selPC=8'h05; next imem_addr=5. BZ 0x09 with zero_flag=0 -> incPC only; with zero_flag=1 -> selPC=8'h09.
- Datapath op 0x3 with exec_done after 3 EXEC cycles -> ir_valid high 4 cycles, one incPC, 7-cycle instruction. Done held low for 16 cycles -> err=1, halted=1, no strobe.
- NOPs from addr 4'hF -> PC wraps to 0, no err. HALT at addr 2 -> halted=1, instr_count=3, run pulses ignored.
- rst_n low mid-EXEC and mid-UPDATE -> all outputs 0 immediately, state IDLE, no trailing strobe; restart with run re-executes INIT.
